tile_painter: RTL and testbench

- Upstream write-side controller for the 8x8 tile memory (64 entries x 9-bit RGB333) that the VGA scan-out reads.
- Turns the board's four push-buttons and switches into write strobes: paint one cell, move a cursor, or clear the whole tile with a fill colour.
- Its we/wa/wv outputs drive the memory write port directly. wa uses the same packing as the read side: wa[5:3]=x, wa[2:0]=y.

---
 rtl/tile_pkg.sv | 27 ++
 rtl/key_debounce.sv | 47 ++++
 rtl/tile_painter.sv | 133 +++++++++++++
 tb/tb_tile_painter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared constants, key indices and FSM state type for the tile painter.
package tile_pkg;

  localparam int TILE_DIM = 8;
  localparam int COORD_W  = 3;
  localparam int ADDR_W   = 6;
  localparam int COLOR_W  = 9;
  localparam int NUM_KEYS = 4;

  localparam int KEY_PAINT = 0;
  localparam int KEY_MOVEX = 1;
  localparam int KEY_MOVEY = 2;
  localparam int KEY_CLEAR = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // One cursor step with natural modulo-8 wrap in both directions.
  function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c,
                                                    input logic dec);
    step_coord = dec ? (c - COORD_W'(1)) : (c + COORD_W'(1));
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, stable-level debounce counter and a
// single-cycle press pulse on each debounced 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic [DB_W-1:0] r_cnt;
  logic            r_press;

  // Synchronise, then accept a new level only after it has been stable long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/tile_painter.sv
// Write-side controller for the 8x8 RGB333 tile memory: paint, cursor move, clear.
// Optional raster-style cursor advance after each paint: TILE_PAINTER_AUTO_ADVANCE_EN.
module tile_painter
  import tile_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [9:0]          sw,
  output logic                we,
  output logic [ADDR_W-1:0]   wa,
  output logic [COLOR_W-1:0]  wv,
  output logic [COORD_W-1:0]  cur_x,
  output logic [COORD_W-1:0]  cur_y,
  output logic                busy
);

  logic [NUM_KEYS-1:0] w_press;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
    ) u_key (
      .clk    (clk),
      .rst    (rst),
      .i_key_n(key_n[g]),
      .o_press(w_press[g])
    );
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_we,    w_we_nxt;
  logic [ADDR_W-1:0]    r_wa,    w_wa_nxt;
  logic [COLOR_W-1:0]   r_wv,    w_wv_nxt;
  logic [COORD_W-1:0]   r_cur_x, w_cur_x_nxt;
  logic [COORD_W-1:0]   r_cur_y, w_cur_y_nxt;
  logic                 r_busy,  w_busy_nxt;
  logic [COORD_W-1:0]   w_base_x;
  logic [COORD_W-1:0]   w_base_y;

  // State and all outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_wa    <= '0;
      r_wv    <= '0;
      r_cur_x <= '0;
      r_cur_y <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_wa    <= w_wa_nxt;
      r_wv    <= w_wv_nxt;
      r_cur_x <= w_cur_x_nxt;
      r_cur_y <= w_cur_y_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Cursor before moves: the raster advance (if enabled) applies on a paint press.
`ifdef TILE_PAINTER_AUTO_ADVANCE_EN
  assign w_base_x = w_press[KEY_PAINT] ? (r_cur_x + COORD_W'(1)) : r_cur_x;
  assign w_base_y = (w_press[KEY_PAINT] && (r_cur_x == COORD_W'(TILE_DIM - 1)))
                    ? (r_cur_y + COORD_W'(1)) : r_cur_y;
`else
  assign w_base_x = r_cur_x;
  assign w_base_y = r_cur_y;
`endif

  // Next-state and next-output logic; r_wa doubles as the clear address counter.
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_wa_nxt    = r_wa;
    w_wv_nxt    = r_wv;
    w_cur_x_nxt = r_cur_x;
    w_cur_y_nxt = r_cur_y;
    w_busy_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press[KEY_CLEAR]) begin
          w_state_nxt = CLEAR;
          w_we_nxt    = 1'b1;
          w_wa_nxt    = '0;
          w_wv_nxt    = sw[COLOR_W-1:0];
          w_busy_nxt  = 1'b1;
        end else begin
          if (w_press[KEY_PAINT]) begin
            w_state_nxt = PAINT;
            w_we_nxt    = 1'b1;
            w_wa_nxt    = {r_cur_x, r_cur_y};
            w_wv_nxt    = sw[COLOR_W-1:0];
          end else begin
            w_state_nxt = IDLE;
          end
          // Moves override the advance per axis and use the pre-move cursor.
          w_cur_x_nxt = w_press[KEY_MOVEX] ? step_coord(r_cur_x, sw[9]) : w_base_x;
          w_cur_y_nxt = w_press[KEY_MOVEY] ? step_coord(r_cur_y, sw[9]) : w_base_y;
        end
      end
      PAINT: begin
        w_state_nxt = IDLE;
      end
      CLEAR: begin
        if (r_wa == ADDR_W'(TILE_DIM * TILE_DIM - 1)) begin
          w_state_nxt = IDLE;
        end else begin
          w_we_nxt   = 1'b1;
          w_wa_nxt   = r_wa + ADDR_W'(1);
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign we    = r_we;
  assign wa    = r_wa;
  assign wv    = r_wv;
  assign cur_x = r_cur_x;
  assign cur_y = r_cur_y;
  assign busy  = r_busy;

endmodule

// File: tb/tb_tile_painter.sv
// Self-checking bench for tile_painter with a transaction-level reference model.
module tb_tile_painter;

  logic        clk;
  logic        rst;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic        we;
  logic [5:0]  wa;
  logic [8:0]  wv;
  logic [2:0]  cur_x;
  logic [2:0]  cur_y;
  logic        busy;

  tile_painter #(.DEBOUNCE_CYCLES(4), .DB_W(3)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .key_n(key_n),
    .sw   (sw),
    .we   (we),
    .wa   (wa),
    .wv   (wv),
    .cur_x(cur_x),
    .cur_y(cur_y),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] obs_q[$];
  logic [14:0] exp_q[$];
  int busy_cnt = 0;
  int busy_bad = 0;
  int exp_busy = 0;
  int mx = 0;
  int my = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample 1 time unit after the rising edge and record writes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (we === 1'b1) obs_q.push_back({wa, wv});
    if (busy === 1'b1) begin
      busy_cnt++;
      if (we !== 1'b1) busy_bad++;
    end
  endtask

  function automatic void model_reset();
    mx = 0;
    my = 0;
    exp_q.delete();
    obs_q.delete();
    busy_cnt = 0;
    busy_bad = 0;
    exp_busy = 0;
  endfunction

  // Effect of one accepted press while the painter is idle.
  function automatic void model_press(input int k, input logic [9:0] s);
    logic [5:0] a;
    case (k)
      0: begin
        a = 6'((mx * 8) + my);
        exp_q.push_back({a, s[8:0]});
`ifdef TILE_PAINTER_AUTO_ADVANCE_EN
        if (mx == 7) my = (my + 1) % 8;
        mx = (mx + 1) % 8;
`endif
      end
      1: mx = s[9] ? (mx + 7) % 8 : (mx + 1) % 8;
      2: my = s[9] ? (my + 7) % 8 : (my + 1) % 8;
      3: begin
        for (int i = 0; i < 64; i++) begin
          a = 6'(i);
          exp_q.push_back({a, s[8:0]});
        end
        exp_busy += 64;
      end
      default: ;
    endcase
  endfunction

  task automatic press(input int k, input logic [9:0] s, input int hold, input int settle);
    sw = s;
    model_press(k, s);
    key_n[k] = 1'b0;
    repeat (hold) tick();
    key_n[k] = 1'b1;
    repeat (settle) tick();
  endtask

  task automatic glitch(input int k, input int len);
    key_n[k] = 1'b0;
    repeat (len) tick();
    key_n[k] = 1'b1;
    repeat (10) tick();
  endtask

  // Compare observed writes and cursor with the model, then start fresh.
  task automatic verify(input string tag);
    int n;
    check({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_wr"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_x"}, 32'(cur_x), 32'(mx));
    check({tag, "_y"}, 32'(cur_y), 32'(my));
    check({tag, "_busy_n"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, "_busy_we"}, 32'(busy_bad), 32'd0);
    obs_q.delete();
    exp_q.delete();
    busy_cnt = 0;
    busy_bad = 0;
    exp_busy = 0;
  endtask

  task automatic move_to(input int tx, input int ty);
    for (int i = 0; i < 8 && mx != tx; i++) press(1, 10'h000, 6, 10);
    for (int i = 0; i < 8 && my != ty; i++) press(2, 10'h000, 6, 10);
  endtask

  initial begin
    int lat_p;
    int lat_w;
    int k;
    int found;
    logic [9:0] s;

    rst   = 1'b0;
    key_n = 4'hF;
    sw    = 10'h000;
    #1 rst = 1'b1;
    #2;
    check("rst_we", 32'(we), 32'd0);
    check("rst_wa", 32'(wa), 32'd0);
    check("rst_wv", 32'(wv), 32'd0);
    check("rst_cur", 32'({cur_x, cur_y}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    repeat (100) tick();
    verify("idle");

    // Debounce behaviour on move X.
    glitch(1, 2);
    verify("glitch");
    press(1, 10'h000, 10, 10);
    verify("hold10");
    press(1, 10'h200, 6, 10);
    press(1, 10'h200, 6, 10);
    verify("dec_wrap");

    // Paint at (3,5) with latency measurement from the internal pulse.
    move_to(3, 5);
    verify("move35");
    sw = 10'h1A5;
    model_press(0, sw);
    lat_p = -1;
    lat_w = -1;
    key_n[0] = 1'b0;
    for (int c = 1; c <= 30 && lat_w < 0; c++) begin
      tick();
      if (u_dut.w_press[0] === 1'b1 && lat_p < 0) lat_p = c;
      if (we === 1'b1) lat_w = c;
    end
    key_n[0] = 1'b1;
    repeat (10) tick();
    check("paint_lat", 32'(lat_w), 32'd7);
    check("paint_pulse_gap", 32'(lat_w - lat_p), 32'd1);
    if (obs_q.size() > 0) check("paint_wa", 32'(obs_q[0][14:9]), 32'h1D);
    verify("paint");

    // Clear sweep with a paint press arriving mid-sweep.
    sw = 10'h0F0;
    model_press(3, sw);
    key_n[3] = 1'b0;
    repeat (6) tick();
    key_n[3] = 1'b1;
    repeat (10) tick();
    sw = 10'h155;
    key_n[0] = 1'b0;
    repeat (6) tick();
    key_n[0] = 1'b1;
    repeat (70) tick();
    check("clr_done_we", 32'(we), 32'd0);
    check("clr_done_busy", 32'(busy), 32'd0);
    verify("clear");

    // Reset in the middle of a clear sweep.
    sw = 10'h03C;
    key_n[3] = 1'b0;
    repeat (6) tick();
    key_n[3] = 1'b1;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      tick();
      if (we === 1'b1 && wa == 6'd20) found = 1;
    end
    check("clr20_seen", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_we", 32'(we), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wa", 32'(wa), 32'd0);
    check("arst_wv", 32'(wv), 32'd0);
    check("arst_cur", 32'({cur_x, cur_y}), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    press(3, 10'h2AA, 6, 80);
    verify("clear2");

    // Paint at the last cell: advance wraps to (0,0) only when enabled.
    move_to(7, 7);
    verify("move77");
    press(0, 10'h0C3, 6, 10);
    check("aa_nwr", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) check("aa_wa", 32'(obs_q[0][14:9]), 32'd63);
`ifdef TILE_PAINTER_AUTO_ADVANCE_EN
    check("aa_cur", 32'({cur_x, cur_y}), 32'd0);
`else
    check("aa_cur", 32'({cur_x, cur_y}), 32'h3F);
`endif
    verify("aa");

    // Randomised operations against the model.
    for (int it = 0; it < 40; it++) begin
      k = int'($urandom_range(0, 4));
      s = 10'($urandom);
      if (k == 4) begin
        glitch(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
      end else begin
        press(k, s, int'($urandom_range(5, 12)), (k == 3) ? 80 : 10);
      end
      verify("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
